lif_neuron: RTL
===============

# lif_neuron

Leaky integrate-and-fire neuron sitting directly downstream of the synapse array. Each enabled cycle it sums the 8-bit activations of `N_SYN` synapses into a saturating membrane potential with shift-based leak. It emits a one-cycle `post_spike` on threshold crossing, then holds off for a refractory period. `post_spike` is fanned back to every synapse as its STDP post-event.

## Interface
- `N_SYN`, 4: number of synapse activation lanes.
- `MEM_W`, 10: membrane width; must be ≥ 8 + clog2(`N_SYN`).
- `THRESH`, 200: firing threshold, unsigned, < 2^`MEM_W`.
- `LEAK_SHIFT`, 3: leak = V >> `LEAK_SHIFT`; 0 disables leak.
- `REFRAC_CYCLES`, 3: enabled cycles spent in REFRACT after a spike; 0 skips REFRACT.
- `THR_STEP`, 16: adaptive threshold increment (used only with the macro).

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: integration tick enable.
- `activation`, in, `N_SYN`*8: lane i = bits [8*i +: 8], one unsigned activation per synapse.
- `post_spike`, out, 1: high for exactly one clk cycle per spike.
- `membrane`, out, `MEM_W`: current membrane register.
- `refractory`, out, 1: high while in REFRACT.

## Operation
- States: INTEG, FIRE, REFRACT. Reset → INTEG, membrane 0, refractory counter 0, adaptive offset 0. All outputs are low/0 during and after reset.
- INTEG, `en`=1:
  - sum = Σ lanes at `MEM_W` bits, no overflow possible.
  - V' = V − (V >> `LEAK_SHIFT`) + sum, saturated at 2^`MEM_W`−1.
  - If V' ≥ effective threshold: membrane ← 0, go to FIRE.
  - Else: membrane ← V'.
- INTEG, `en`=0: hold everything.
- FIRE: `post_spike`=1, membrane held 0, inputs ignored. Leaves after exactly one clk cycle regardless of `en`: to REFRACT with counter ← `REFRAC_CYCLES` if `REFRAC_CYCLES`>0, else to INTEG.
- REFRACT: `refractory`=1, membrane held 0, inputs ignored. Counter decrements on each `en`=1 cycle. When the counter reaches 0, go to INTEG on that edge. `en`=0 freezes the counter.
- Effective threshold = `THRESH` without the macro.
- Reset asserted in any state returns to the reset state immediately; any in-progress spike or refractory period is aborted.

## Timing
- `post_spike` is decoded from the state register. It is high during the cycle following the crossing edge, so latency from the sampled activation is 1 cycle.
- Minimum inter-spike spacing is `REFRAC_CYCLES`+2 cycles with `en` held high.
- `membrane` and `refractory` are registered outputs with no combinational path from inputs.
- Sum and leak are single-cycle combinational; no pipelining.

## Configuration
- `LIF_ADAPTIVE_THRESH_EN` defined:
  - Adds an 8-bit adaptive offset register.
  - On entering FIRE: offset ← min(offset + `THR_STEP`, 255).
  - On every `en`=1 cycle not entering FIRE: offset decrements by 1 if nonzero.
  - Effective threshold = min(`THRESH` + offset, 2^`MEM_W`−1).
- Not defined: no offset register; the threshold is the constant `THRESH`.

## Structure
- Package `lif_pkg`:
  - State enum `lif_state_t` (INTEG, FIRE, REFRACT).
  - Activation width constant `ACT_W`=8.
  - Saturating-add helper function.
- Sub-module `lif_accum`: combinational `N_SYN`-lane adder tree producing the `MEM_W`-bit sum.
- Top level holds the FSM, the membrane and counter registers, and the optional offset register.

## Test plan
All scenarios use defaults unless stated.

- Reset: drive `reset`=0 with random inputs → `post_spike`=0, `membrane`=0, `refractory`=0. Release with all-zero inputs → values stay 0.
- Integration to fire: lane0=50, others 0, `en`=1.
  - Membrane sequence 50, 94, 133, 167, 197.
  - Sixth edge crosses (223) → `membrane`=0 and `post_spike`=1 the following cycle.
- Leak only: one cycle with all lanes=40 → membrane 160. Then zero inputs → 140, 123, 108. With `en`=0, membrane holds at 108.
- Refractory/spacing: lane0=255 constant → `post_spike` every 5 cycles. `refractory`=1 for 3 cycles after each spike; membrane is 0 throughout.
- Saturation: `THRESH`=1023, all lanes=255.
  - First edge → 1020.
  - Second edge → saturates at 1023 → fires.
- Reset mid-REFRACT: assert `reset` one cycle into REFRACT → immediate return to INTEG, membrane 0. After release, the first 255 input fires without waiting out the old refractory count.
- With `LIF_ADAPTIVE_THRESH_EN` defined, using the integration scenario: after the first spike the effective threshold is 216 minus the elapsed decay.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
// Holds the FSM state encoding, activation width and a saturating adder.
package lif_pkg;

    localparam int ACT_W = 8;
    localparam int OFS_W = 8;
    localparam logic [31:0] OFS_MAX = 32'd255;

    typedef enum logic [1:0] {
        INTEG   = 2'd0,
        FIRE    = 2'd1,
        REFRACT = 2'd2
    } lif_state_t;

    // Unsigned a + b clamped to lim; callers keep operands well below 2^32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/lif_accum.sv
// Combinational adder tree summing N_SYN unsigned 8-bit synapse activations
// into a MEM_W-bit result (MEM_W sized so the sum cannot overflow).
module lif_accum
    import lif_pkg::*;
#(
    parameter int N_SYN = 4,
    parameter int MEM_W = 10
) (
    input  logic [N_SYN*ACT_W-1:0] activation,
    output logic [MEM_W-1:0]       sum
);

    localparam int LEVELS = $clog2(N_SYN);
    localparam int LANES  = 1 << LEVELS;

    // Heap-ordered tree: node k adds children 2k+1 and 2k+2, leaves at the tail.
    logic [MEM_W-1:0] tree [2*LANES-1];

    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        if (i < N_SYN) begin : g_lane
            assign tree[LANES-1+i] = MEM_W'(activation[ACT_W*i +: ACT_W]);
        end else begin : g_pad
            assign tree[LANES-1+i] = '0;
        end
    end

    for (genvar k = 0; k < LANES - 1; k++) begin : g_node
        assign tree[k] = tree[2*k+1] + tree[2*k+2];
    end

    assign sum = tree[0];

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane with shift leak, one-cycle
// spike, refractory hold-off. LIF_ADAPTIVE_THRESH_EN adds an adaptive threshold offset.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int N_SYN         = 4,
    parameter int MEM_W         = 10,
    parameter int THRESH        = 200,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 3,
    parameter int THR_STEP      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N_SYN*ACT_W-1:0] activation,
    output logic                   post_spike,
    output logic [MEM_W-1:0]       membrane,
    output logic                   refractory,
    output lif_state_t             dbg_state
);

    localparam logic [31:0] MEM_MAX = (32'd1 << MEM_W) - 32'd1;
    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    lif_state_t       state_q, state_d;
    logic [MEM_W-1:0] mem_q, mem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             refr_q;

    logic [MEM_W-1:0] sum;
    logic [MEM_W-1:0] leak_amt;
    logic [MEM_W-1:0] leaked;
    logic [MEM_W-1:0] v_new;
    logic [31:0]      eff_thr;
    logic             crossing;

    lif_accum #(
        .N_SYN (N_SYN),
        .MEM_W (MEM_W)
    ) u_accum (
        .activation (activation),
        .sum        (sum)
    );

    // A zero shift means "no leak", not "leak everything".
    assign leak_amt = (LEAK_SHIFT == 0) ? '0 : (mem_q >> LEAK_SHIFT);
    assign leaked   = mem_q - leak_amt;
    assign v_new    = MEM_W'(sat_add(32'(leaked), 32'(sum), MEM_MAX));
    assign crossing = (32'(v_new) >= eff_thr);

`ifdef LIF_ADAPTIVE_THRESH_EN
    logic [OFS_W-1:0] ofs_q, ofs_d;
    logic             fire_enter;

    assign fire_enter = (state_q == INTEG) && en && crossing;
    assign eff_thr    = sat_add(32'(THRESH), 32'(ofs_q), MEM_MAX);

    always_comb begin
        ofs_d = ofs_q;
        if (fire_enter) begin
            ofs_d = OFS_W'(sat_add(32'(ofs_q), 32'(THR_STEP), OFS_MAX));
        end else if (en && (ofs_q != '0)) begin
            ofs_d = ofs_q - OFS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ofs_q <= '0;
        end else begin
            ofs_q <= ofs_d;
        end
    end
`else
    assign eff_thr = 32'(THRESH);
`endif

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        case (state_q)
            INTEG: begin
                if (en) begin
                    if (crossing) begin
                        mem_d   = '0;
                        state_d = FIRE;
                    end else begin
                        mem_d = v_new;
                    end
                end
            end
            FIRE: begin
                mem_d = '0;
                if (REFRAC_CYCLES > 0) begin
                    state_d = REFRACT;
                    cnt_d   = CNT_W'(REFRAC_CYCLES);
                end else begin
                    state_d = INTEG;
                end
            end
            REFRACT: begin
                mem_d = '0;
                // The edge that takes the count to zero is also the exit edge.
                if (en) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = INTEG;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = INTEG;
                mem_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INTEG;
            mem_q   <= '0;
            cnt_q   <= '0;
            refr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            refr_q  <= (state_d == REFRACT);
        end
    end

    assign post_spike = (state_q == FIRE);
    assign membrane   = mem_q;
    assign refractory = refr_q;
    assign dbg_state  = state_q;

endmodule
